// File: rtl/inv_shiftrows_serial.sv
// Byte-serial AES InvShiftRows stage.
// Bytes arrive in column-major order and are scattered directly into their
// InvShiftRows destination slot, so the permutation itself costs no cycle.
// A finished block is presented on a registered valid/ready output; one extra
// block can wait in the assembly register while the output is stalled.
module inv_shiftrows_serial #(
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned N_BYTES = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [NB_BYTE-1:0]         i_byte,
  input  logic                       i_valid,
  input  logic                       i_last,
  output logic                       o_ready,
  output logic [N_BYTES*NB_BYTE-1:0] o_state,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_error,
  output logic                       o_busy
);

  localparam int unsigned StateW = N_BYTES * NB_BYTE;

  // Only the AES geometry (16 bytes of 8 bits) is meaningful here.
  if (NB_BYTE != 8 || N_BYTES != 16) begin : gen_bad_cfg
    $error("inv_shiftrows_serial: only NB_BYTE=8 and N_BYTES=16 are supported");
  end

  // State registers.
  logic [3:0]        cnt_q,      cnt_d;
  logic [StateW-1:0] asm_q,      asm_d;
  logic              asm_full_q, asm_full_d;
  logic [StateW-1:0] state_q,    state_d;
  logic              valid_q,    valid_d;
  logic              error_q,    error_d;

  // Decoded handshake and framing conditions.
  logic              accept;
  logic              last_slot;
  logic              frame_err;
  logic              complete;
  logic              out_free;
  logic              drain_asm;

  // Destination slot for the incoming byte.
  logic [1:0]        row;
  logic [1:0]        col;
  logic [1:0]        dst_col;
  logic [3:0]        dst_idx;
  logic [StateW-1:0] asm_wr;

  // No path from i_ready: input side stalls only on a parked block.
  assign o_ready = i_reset_n & ~asm_full_q;

  // Scatter the current byte into its InvShiftRows slot: in(r,c) -> out(r,(c+r) mod 4).
  always_comb begin
    row     = cnt_q[1:0];
    col     = cnt_q[3:2];
    dst_col = col + row;  // 2-bit add wraps mod 4
    dst_idx = {dst_col, row};
    asm_wr  = asm_q;
    for (int unsigned s = 0; s < N_BYTES; s++) begin
      if (dst_idx == 4'(s)) begin
        asm_wr[s*NB_BYTE +: NB_BYTE] = i_byte;
      end
    end
  end

  // Next-state logic for counter, assembly buffer and output slot.
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    state_d    = state_q;
    valid_d    = valid_q;
    error_d    = 1'b0;

    accept    = i_valid & o_ready;
    last_slot = (cnt_q == 4'd15);
    frame_err = accept & (i_last ^ last_slot);
    complete  = accept & i_last & last_slot;
    out_free  = ~valid_q | i_ready;
    drain_asm = asm_full_q & i_ready;

    if (accept) begin
      asm_d = asm_wr;
      // A good block wraps 15 -> 0 naturally; a framing error restarts the count.
      cnt_d = frame_err ? 4'd0 : cnt_q + 4'd1;
    end
    error_d = frame_err;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (drain_asm) begin
      // accept is impossible here since o_ready is low while asm_full_q is set.
      state_d    = asm_q;
      valid_d    = 1'b1;
      asm_full_d = 1'b0;
    end else if (complete) begin
      if (out_free) begin
        state_d = asm_wr;
        valid_d = 1'b1;
      end else begin
        asm_full_d = 1'b1;
      end
    end
  end

  // Synchronous active-low reset clears all state, including buffered blocks.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      cnt_q      <= 4'd0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      state_q    <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign o_state = state_q;
  assign o_valid = valid_q;
  assign o_error = error_q;
  assign o_busy  = (cnt_q != 4'd0);

endmodule

// File: tb/tb_inv_shiftrows_serial.sv
// Scoreboard bench for inv_shiftrows_serial: stimulus pushes the model's
// expected state, a negedge monitor pops on every output handshake.
module tb_inv_shiftrows_serial;

  logic         i_clock = 1'b0;
  logic         i_reset_n = 1'b0;
  logic [7:0]   i_byte = 8'h00;
  logic         i_valid = 1'b0;
  logic         i_last = 1'b0;
  logic         o_ready;
  logic [127:0] o_state;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic         o_error;
  logic         o_busy;

  int           n_checks = 0;
  int           n_fail = 0;
  int           stall_cycles = 0;
  int           ready_ctl = 0;  // 0: hold low, 1: hold high, 2: random
  logic [127:0] exp_q[$];
  logic         hold_prev = 1'b0;
  logic [127:0] prev_state = '0;

  inv_shiftrows_serial #(
    .NB_BYTE(8),
    .N_BYTES(16)
  ) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_byte   (i_byte),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .o_state  (o_state),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_error  (o_error),
    .o_busy   (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Downstream ready, updated away from both edges.
  always @(posedge i_clock) begin
    #2;
    case (ready_ctl)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference: out(r,c) = in(r,(c-r) mod 4), byte (r,c) at bits 8*(4c+r).
  function automatic logic [127:0] inv_shift(input logic [127:0] in);
    logic [127:0] out;
    out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        out[8*(4*c+r) +: 8] = in[8*(4*((c - r + 4) % 4) + r) +: 8];
      end
    end
    return out;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the byte handshake.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int waits;
    waits   = 0;
    i_byte  = b;
    i_last  = last;
    i_valid = 1'b1;
    @(negedge i_clock);
    while (!o_ready && waits < 300) begin
      waits++;
      stall_cycles++;
      @(negedge i_clock);
    end
    if (waits >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: o_ready stuck at 0 for %0d cycles, expected 1", waits);
    end
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge i_clock);
          #1;
        end
      end
      send_byte(blk[8*k +: 8], k == 15);
    end
    exp_q.push_back(inv_shift(blk));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output monitor: hold-stability and scoreboard compare on each handshake.
  always @(negedge i_clock) begin
    if (!i_reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_checks++;
        if (!o_valid || o_state !== prev_state) begin
          n_fail++;
          $display("FAIL hold: valid=%b state=%h, expected valid=1 state=%h",
                   o_valid, o_state, prev_state);
        end
      end
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output", o_state);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          if (o_state !== e) begin
            n_fail++;
            $display("FAIL output_data: got %h, expected %h", o_state, e);
          end
        end
      end
      hold_prev  = o_valid && !i_ready;
      prev_state = o_state;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] seq;
    int           waits;

    // Reset state.
    ready_ctl = 0;
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_state", o_state, '0);
    check("rst_error", 128'(o_error), 128'(0));
    check("rst_busy",  128'(o_busy), 128'(0));
    check("rst_ready", 128'(o_ready), 128'(0));
    i_reset_n = 1'b1;
    ready_ctl = 1;
    #1;
    check("ready_after_rst", 128'(o_ready), 128'(1));
    idle(2);

    // Single block 0x00..0x0F, one-cycle latency, known answer.
    for (int k = 0; k < 16; k++) seq[8*k +: 8] = 8'(k);
    send_block(seq, 1'b0);
    check("single_valid", 128'(o_valid), 128'(1));
    check("single_kat", o_state, 128'h0306090C0F0205080B0E0104070A0D00);
    check("single_busy", 128'(o_busy), 128'(0));
    idle(3);

    // Back-to-back blocks with no bubbles.
    stall_cycles = 0;
    for (int b = 0; b < 4; b++) send_block(rand_block(), 1'b0);
    check("b2b_no_stall", 128'(stall_cycles), 128'(0));
    idle(3);

    // Backpressure: A stalls in the output, B parks in assembly.
    blk_a = rand_block();
    blk_b = rand_block();
    send_block(blk_a, 1'b0);
    ready_ctl = 0;
    send_block(blk_b, 1'b0);
    check("bp_ready_low", 128'(o_ready), 128'(0));
    check("bp_state_a", o_state, inv_shift(blk_a));
    idle(3);
    check("bp_ready_still_low", 128'(o_ready), 128'(0));
    check("bp_state_a_held", o_state, inv_shift(blk_a));
    ready_ctl = 1;
    idle(1);
    check("bp_ready_back", 128'(o_ready), 128'(1));
    check("bp_valid_b", 128'(o_valid), 128'(1));
    check("bp_state_b", o_state, inv_shift(blk_b));
    idle(3);

    // Early last on byte 5.
    for (int k = 0; k < 6; k++) send_byte(8'($urandom), k == 5);
    check("early_error", 128'(o_error), 128'(1));
    check("early_busy", 128'(o_busy), 128'(0));
    check("early_valid", 128'(o_valid), 128'(0));
    idle(1);
    check("early_error_pulse", 128'(o_error), 128'(0));
    send_block(rand_block(), 1'b0);
    idle(3);

    // Missing last on byte 15.
    for (int k = 0; k < 16; k++) send_byte(8'($urandom), 1'b0);
    check("miss_error", 128'(o_error), 128'(1));
    check("miss_busy", 128'(o_busy), 128'(0));
    check("miss_valid", 128'(o_valid), 128'(0));
    idle(1);
    check("miss_error_pulse", 128'(o_error), 128'(0));
    send_block(rand_block(), 1'b0);
    idle(3);

    // Reset mid-block with a block pending on the output.
    ready_ctl = 0;
    send_block(rand_block(), 1'b0);
    blk_b = rand_block();
    for (int k = 0; k < 9; k++) send_byte(blk_b[8*k +: 8], 1'b0);
    check("pre_rst_busy", 128'(o_busy), 128'(1));
    i_reset_n = 1'b0;
    idle(1);
    check("midrst_valid", 128'(o_valid), 128'(0));
    check("midrst_busy", 128'(o_busy), 128'(0));
    check("midrst_state", o_state, '0);
    check("midrst_ready", 128'(o_ready), 128'(0));
    exp_q.delete();
    i_reset_n = 1'b1;
    ready_ctl = 1;
    #1;
    check("midrst_ready_release", 128'(o_ready), 128'(1));
    idle(1);
    send_block(rand_block(), 1'b0);
    idle(3);

    // Randomized traffic with gaps and random backpressure.
    ready_ctl = 2;
    for (int b = 0; b < 24; b++) send_block(rand_block(), 1'b1);
    ready_ctl = 1;
    waits = 0;
    while (exp_q.size() != 0 && waits < 200) begin
      idle(1);
      waits++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
